// File: rtl/bcd_stopwatch_pkg.sv
// Shared types and constants for the BCD stopwatch: digit type, run-state
// encoding, digit moduli and a small BCD conversion helper.
package bcd_stopwatch_pkg;

   typedef logic [3:0] bcd_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   localparam int DIGIT_MOD_DEC           = 10;
   localparam int DIGIT_MOD_SEXT          = 6;
   localparam int DEFAULT_TICKS_PER_TENTH = 5000000;
   localparam int DEFAULT_WRAP_MINUTES    = 60;

   // Digit order, least significant first: tenths, secOnes, secTens, minOnes, minTens.
   localparam int NUM_DIGITS = 5;

   function automatic int digit_modulus(input int idx);
      return (idx == 2) ? DIGIT_MOD_SEXT : DIGIT_MOD_DEC;
   endfunction

   function automatic logic [7:0] to_bcd2(input int value);
      return {4'(value / 10), 4'(value % 10)};
   endfunction

endpackage

// File: rtl/bcd_stopwatch_if.sv
// Control pulses and display-side outputs of the stopwatch, bundled for
// connection between the button logic and the seven-segment decoders.
interface bcd_stopwatch_if;
   import bcd_stopwatch_pkg::*;

   logic startStop;
   logic clear;
   logic lap;
   logic running;
   logic tick;
   logic wrap;
   logic lapActive;
   bcd_t tenths;
   bcd_t secOnes;
   bcd_t secTens;
   bcd_t minOnes;
   bcd_t minTens;

   modport master (
      output startStop, clear, lap,
      input  running, tick, wrap, lapActive,
      input  tenths, secOnes, secTens, minOnes, minTens
   );

   modport slave (
      input  startStop, clear, lap,
      output running, tick, wrap, lapActive,
      output tenths, secOnes, secTens, minOnes, minTens
   );

endinterface

// File: rtl/bcd_stopwatch_digit_counter.sv
// Single BCD digit counting 0..MODULUS-1; advances on en, synchronous clr wins,
// carry_out flags the enabled step from MODULUS-1 back to 0.
module bcd_digit_counter
   import bcd_stopwatch_pkg::*;
#(
   parameter int MODULUS = DIGIT_MOD_DEC
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output bcd_t digit,
   output logic carry_out
);

   localparam bcd_t DIGIT_MAX = bcd_t'(MODULUS - 1);

   bcd_t digit_q;
   bcd_t digit_d;

   always_comb begin
      digit_d = digit_q;
      if (clr) begin
         digit_d = '0;
      end else if (en) begin
         digit_d = (digit_q == DIGIT_MAX) ? '0 : digit_q + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digit_q <= '0;
      end else begin
         digit_q <= digit_d;
      end
   end

   assign digit     = digit_q;
   assign carry_out = en && (digit_q == DIGIT_MAX);

endmodule

// File: rtl/bcd_stopwatch.sv
// Stopwatch top: run/pause FSM, tenth-second prescaler and MM:SS.t digit cascade.
// Optional lap hold (snapshot display while counting continues) under LAP_HOLD_EN.
module bcd_stopwatch
   import bcd_stopwatch_pkg::*;
#(
   parameter int TICKS_PER_TENTH = DEFAULT_TICKS_PER_TENTH,
   parameter int WRAP_MINUTES    = DEFAULT_WRAP_MINUTES
) (
   input logic            CLOCK_50,
   input logic            RESET_N,
   bcd_stopwatch_if.slave bus
);

   localparam int                 PRESC_W     = $clog2(TICKS_PER_TENTH);
   localparam logic [PRESC_W-1:0] PRESC_MAX   = PRESC_W'(TICKS_PER_TENTH - 1);
   localparam logic [7:0]         MIN_MAX_BCD = to_bcd2(WRAP_MINUTES - 1);

   state_t             state_q, state_d;
   logic [PRESC_W-1:0] presc_q, presc_d;
   logic               running_q, running_d;
   logic               tick_q, tick_d;
   logic               wrap_q, wrap_d;
   logic               tick_event;
   logic               minute_wrap;
   bcd_t               live_w  [NUM_DIGITS];
   bcd_t               shown_w [NUM_DIGITS];

   // A tick is decided by the pre-edge state, so a startStop on a tick edge still counts.
   assign tick_event  = (state_q == RUN) && (presc_q == PRESC_MAX);
   assign minute_wrap = g_digit[2].carry && ({live_w[4], live_w[3]} == MIN_MAX_BCD);

   always_comb begin
      state_d = state_q;
      if (bus.clear) begin
         state_d = IDLE;
      end else if (bus.startStop) begin
         case (state_q)
            IDLE:    state_d = RUN;
            RUN:     state_d = PAUSE;
            PAUSE:   state_d = RUN;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      presc_d = presc_q;
      if (bus.clear) begin
         presc_d = '0;
      end else if (state_q == RUN) begin
         presc_d = tick_event ? '0 : presc_q + PRESC_W'(1);
      end
      running_d = (state_d == RUN);
      tick_d    = tick_event && !bus.clear;
      wrap_d    = minute_wrap && !bus.clear;
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q   <= IDLE;
         presc_q   <= '0;
         running_q <= 1'b0;
         tick_q    <= 1'b0;
         wrap_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         presc_q   <= presc_d;
         running_q <= running_d;
         tick_q    <= tick_d;
         wrap_q    <= wrap_d;
      end
   end

   // Both minute digits are forced to zero at the configured wrap point.
   for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic en;
      logic clr;
      logic carry;

      if (gi == 0) begin : g_lsd
         assign en = tick_event;
      end else begin : g_chain
         assign en = g_digit[gi-1].carry;
      end

      assign clr = bus.clear || ((gi >= 3) && minute_wrap);

      bcd_digit_counter #(
         .MODULUS (digit_modulus(gi))
      ) u_digit (
         .clk       (CLOCK_50),
         .rst_n     (RESET_N),
         .en        (en),
         .clr       (clr),
         .digit     (live_w[gi]),
         .carry_out (carry)
      );
   end

   logic unused_carry;
   assign unused_carry = g_digit[NUM_DIGITS-1].carry;

`ifdef LAP_HOLD_EN
   logic lap_active_q, lap_active_d;
   bcd_t snap_q [NUM_DIGITS];
   bcd_t snap_d [NUM_DIGITS];

   always_comb begin
      lap_active_d = lap_active_q;
      snap_d       = snap_q;
      if (bus.clear) begin
         lap_active_d = 1'b0;
      end else if (bus.lap && (state_q != IDLE)) begin
         lap_active_d = !lap_active_q;
         if (!lap_active_q) begin
            snap_d = live_w;
         end
      end
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         lap_active_q <= 1'b0;
         snap_q       <= '{default: '0};
      end else begin
         lap_active_q <= lap_active_d;
         snap_q       <= snap_d;
      end
   end

   for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_show
      assign shown_w[gi] = lap_active_q ? snap_q[gi] : live_w[gi];
   end

   assign bus.lapActive = lap_active_q;
`else
   logic unused_lap;
   assign unused_lap = bus.lap;

   for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_show
      assign shown_w[gi] = live_w[gi];
   end

   assign bus.lapActive = 1'b0;
`endif

   assign bus.running = running_q;
   assign bus.tick    = tick_q;
   assign bus.wrap    = wrap_q;
   assign bus.tenths  = shown_w[0];
   assign bus.secOnes = shown_w[1];
   assign bus.secTens = shown_w[2];
   assign bus.minOnes = shown_w[3];
   assign bus.minTens = shown_w[4];

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Directed bench for bcd_stopwatch with TICKS_PER_TENTH=4, WRAP_MINUTES=2.
// Digits are compared packed as {minTens,minOnes,secTens,secOnes,tenths}.
module tb_bcd_stopwatch;
   import bcd_stopwatch_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;
   int   ticks_seen;

   bcd_stopwatch_if sw_if ();

   bcd_stopwatch #(
      .TICKS_PER_TENTH (4),
      .WRAP_MINUTES    (2)
   ) dut (
      .CLOCK_50 (clk),
      .RESET_N  (rst_n),
      .bus      (sw_if)
   );

   always #5 clk = ~clk;

   logic [19:0] digits;
   assign digits = {sw_if.minTens, sw_if.minOnes, sw_if.secTens, sw_if.secOnes, sw_if.tenths};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n           = 1'b0;
      sw_if.startStop = 1'b0;
      sw_if.clear     = 1'b0;
      sw_if.lap       = 1'b0;
      #12;
      chk("reset_running", sw_if.running, 0);
      chk("reset_tick", sw_if.tick, 0);
      chk("reset_wrap", sw_if.wrap, 0);
      chk("reset_lap", sw_if.lapActive, 0);
      chk("reset_digits", digits, 20'h00000);
      step(1);
      rst_n = 1'b1;
      step(2);
      chk("idle_digits", digits, 20'h00000);

      // Start: edge 0 samples the pulse.
      sw_if.startStop = 1'b1; step(1); sw_if.startStop = 1'b0;
      chk("start_running", sw_if.running, 1);
      step(3);
      chk("pre_tick", sw_if.tick, 0);
      chk("pre_tick_digits", digits, 20'h00000);
      step(1);
      $display("edge 4: tick=%0b digits=%05h", sw_if.tick, digits);
      chk("first_tick", sw_if.tick, 1);
      chk("first_tenth", digits, 20'h00001);
      step(1);
      chk("tick_one_cycle", sw_if.tick, 0);
      step(31);
      chk("edge36", digits, 20'h00009);
      step(4);
      chk("edge40", digits, 20'h00010);

      // 00:59.9 -> 01:00.0
      step(2356);
      chk("sec_max", digits, 20'h00599);
      step(3);
      chk("sec_max_hold", digits, 20'h00599);
      step(1);
      $display("edge 2400: digits=%05h wrap=%0b", digits, sw_if.wrap);
      chk("minute_carry", digits, 20'h01000);
      chk("minute_carry_wrap", sw_if.wrap, 0);

      // 01:59.9 -> 00:00.0 with wrap strobe
      step(2396);
      chk("wrap_max", digits, 20'h01599);
      step(4);
      $display("edge 4800: digits=%05h wrap=%0b running=%0b", digits, sw_if.wrap, sw_if.running);
      chk("wrap_digits", digits, 20'h00000);
      chk("wrap_strobe", sw_if.wrap, 1);
      chk("wrap_running", sw_if.running, 1);
      step(1);
      chk("wrap_one_cycle", sw_if.wrap, 0);

      // Pause with prescaler at 2, hold 100 cycles, resume.
      sw_if.startStop = 1'b1; step(1); sw_if.startStop = 1'b0;
      chk("pause_running", sw_if.running, 0);
      ticks_seen = 0;
      for (int i = 0; i < 100; i++) begin
         step(1);
         if (sw_if.tick) ticks_seen++;
      end
      chk("pause_ticks", ticks_seen, 0);
      chk("pause_digits", digits, 20'h00000);
      sw_if.startStop = 1'b1; step(1); sw_if.startStop = 1'b0;
      chk("resume_running", sw_if.running, 1);
      step(1);
      chk("resume_no_tick", sw_if.tick, 0);
      step(1);
      $display("resume+2: tick=%0b digits=%05h", sw_if.tick, digits);
      chk("resume_tick", sw_if.tick, 1);
      chk("resume_digits", digits, 20'h00001);

      // clear + startStop on a tick edge: clear wins.
      step(3);
      sw_if.clear = 1'b1; sw_if.startStop = 1'b1; step(1);
      sw_if.clear = 1'b0; sw_if.startStop = 1'b0;
      $display("clear: running=%0b tick=%0b digits=%05h", sw_if.running, sw_if.tick, digits);
      chk("clear_running", sw_if.running, 0);
      chk("clear_tick", sw_if.tick, 0);
      chk("clear_digits", digits, 20'h00000);
      step(8);
      chk("clear_stays_idle", digits, 20'h00000);

`ifdef LAP_HOLD_EN
      sw_if.lap = 1'b1; step(1); sw_if.lap = 1'b0;
      chk("lap_idle_ignored", sw_if.lapActive, 0);
      sw_if.startStop = 1'b1; step(1); sw_if.startStop = 1'b0;
      step(52);
      chk("lap_pre", digits, 20'h00013);
      sw_if.lap = 1'b1; step(1); sw_if.lap = 1'b0;
      chk("lap_active", sw_if.lapActive, 1);
      chk("lap_snapshot", digits, 20'h00013);
      step(79);
      chk("lap_live_tick", sw_if.tick, 1);
      chk("lap_frozen", digits, 20'h00013);
      step(1);
      sw_if.lap = 1'b1; step(1); sw_if.lap = 1'b0;
      $display("lap release: lapActive=%0b digits=%05h", sw_if.lapActive, digits);
      chk("lap_release", sw_if.lapActive, 0);
      chk("lap_live", digits, 20'h00033);
      sw_if.lap = 1'b1; step(1); sw_if.lap = 1'b0;
      chk("lap_again", sw_if.lapActive, 1);
      sw_if.clear = 1'b1; step(1); sw_if.clear = 1'b0;
      chk("lap_clear", sw_if.lapActive, 0);
      chk("lap_clear_digits", digits, 20'h00000);
`else
      sw_if.startStop = 1'b1; step(1); sw_if.startStop = 1'b0;
      step(53);
      sw_if.lap = 1'b1; step(1); sw_if.lap = 1'b0;
      chk("nolap_active", sw_if.lapActive, 0);
      chk("nolap_digits", digits, 20'h00013);
      step(80);
      chk("nolap_live", digits, 20'h00033);
      sw_if.clear = 1'b1; step(1); sw_if.clear = 1'b0;
      chk("nolap_clear", digits, 20'h00000);
`endif

      // Asynchronous reset mid-count.
      sw_if.startStop = 1'b1; step(1); sw_if.startStop = 1'b0;
      step(10);
      chk("pre_reset_digits", digits, 20'h00002);
      #1 rst_n = 1'b0;
      #1;
      $display("async reset: running=%0b digits=%05h", sw_if.running, digits);
      chk("async_reset_running", sw_if.running, 0);
      chk("async_reset_digits", digits, 20'h00000);
      step(2);
      rst_n = 1'b1;
      step(6);
      chk("post_reset_idle", digits, 20'h00000);
      chk("post_reset_running", sw_if.running, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
